// File: rtl/binary_counter_if.sv
// Count-port bundle for binary_counter: direction select in, registered count out.
interface binary_counter_if #(
  parameter int WIDTH = 4
);
  logic             down;
  logic [WIDTH-1:0] q_out;

  modport master (output down, input  q_out);
  modport slave  (input  down, output q_out);
endinterface

// File: rtl/binary_counter.sv
// Free-running WIDTH-bit up/down counter; steps every clk edge, wraps modulo 2^WIDTH.
module binary_counter #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  binary_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;

  // Natural unsigned overflow of the WIDTH-bit register provides the wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      count_q <= '0;
    else if (bus.down)
      count_q <= count_q - ONE;
    else
      count_q <= count_q + ONE;
  end

  assign bus.q_out = count_q;
endmodule

// File: tb/tb_binary_counter.sv
// Self-checking bench for binary_counter: directed phases, then randomized steps vs a modular-arithmetic model.
module tb_binary_counter;
  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic clk;
  logic n_rst;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   exp_q    = 0;

  binary_counter_if #(.WIDTH(W)) bus ();

  binary_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int e);
    logic [W-1:0] e_v;
    e_v = e[W-1:0];
    chk_cnt++;
    assert (bus.q_out === e_v) pass_cnt++;
    else $error("FAIL %s: q_out=%0d expected=%0d", tag, bus.q_out, e_v);
  endtask

  // Drive direction on the falling edge, let one rising edge count, then compare.
  task automatic step(input logic d, input string tag);
    @(negedge clk);
    bus.down = d;
    @(posedge clk);
    #1;
    exp_q = d ? (exp_q + MOD - 1) % MOD : (exp_q + 1) % MOD;
    check(tag, exp_q);
  endtask

  // Pull reset low between edges, confirm it clears before the next rising edge, hold, release after a rising edge.
  task automatic mid_reset(input int hold_cycles, input string tag);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    exp_q = 0;
    check(tag, 0);
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      bus.down = 1'($urandom_range(0, 1));
      #1 check({tag, "_hold"}, 0);
    end
    @(posedge clk);
    #2 n_rst = 1'b1;
  endtask

  initial begin
    n_rst    = 1'b0;
    bus.down = 1'b0;

    // Reset held with clock running and direction toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.down = 1'($urandom_range(0, 1));
      #1 check("reset_hold", 0);
    end
    @(negedge clk);
    bus.down = 1'b0;
    @(posedge clk);
    #2 n_rst = 1'b1;
    exp_q = 0;
    check("reset_release", 0);

    for (int i = 0; i < 16; i++) step(1'b0, "up_wrap");
    check("up_end_zero", 0);
    for (int i = 0; i < 16; i++) step(1'b1, "down_wrap");
    check("down_end_zero", 0);

    for (int i = 0; i < 5; i++) step(1'b0, "to_five");
    check("at_five", 5);
    step(1'b1, "switch_dn1");
    check("switch_dn1_val", 4);
    step(1'b1, "switch_dn2");
    check("switch_dn2_val", 3);
    step(1'b0, "switch_up1");
    check("switch_up1_val", 4);
    step(1'b0, "switch_up2");
    check("switch_up2_val", 5);

    for (int i = 0; i < 4; i++) step(1'b0, "to_nine");
    check("at_nine", 9);
    mid_reset(3, "async_rst");
    step(1'b0, "post_rst_first");
    check("post_rst_one", 1);

    // Randomized walk with occasional asynchronous resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0)
        mid_reset(int'($urandom_range(0, 2)), "rand_rst");
      else
        step(1'($urandom_range(0, 1)), "rand_step");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
